sh7604_ibus_master: RTL and testbench

SH7604_IBUS_MASTER -- requirements
Module: sh7604_ibus_master

---
 rtl/sh7604_pkg.sv | 34 +++
 rtl/sh7604_ibus_if.sv | 22 ++
 rtl/sh7604_ibus_lanes.sv | 55 +++++
 rtl/sh7604_ibus_master.sv | 170 +++++++++++++++++
 tb/tb_sh7604_ibus_master.sv | 274 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/sh7604_pkg.sv
// Shared types and defaults for the SH7604 internal-bus master.
// Holds the access-size and state enums plus helper functions.
package sh7604_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'd0,
    SZ_WORD = 2'd1,
    SZ_LONG = 2'd2
  } ibus_sz_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2
  } ibus_state_e;

  localparam logic [31:0] REGION_BASE_DEF = 32'hFFFFFE00;
  localparam logic [7:0]  TIMEOUT_DEF     = 8'd255;

  // CPU size code 3 behaves as a long access.
  function automatic ibus_sz_e norm_sz(logic [1:0] sz);
    norm_sz = (sz == 2'd3) ? SZ_LONG : ibus_sz_e'(sz);
  endfunction

  function automatic logic misaligned(ibus_sz_e sz,
                                      logic [1:0] a);
    unique case (sz)
      SZ_WORD: misaligned = a[0];
      SZ_LONG: misaligned = |a;
      default: misaligned = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/sh7604_ibus_if.sv
// Internal peripheral bus bundle: address/data/enables out, data and
// BUSY/ACT responder status in. master drives requests, slave answers.
interface sh7604_ibus_if;
  logic [31:0] IBUS_A;
  logic [31:0] IBUS_DO;
  logic [3:0]  IBUS_BA;
  logic        IBUS_WE;
  logic        IBUS_REQ;
  logic [31:0] IBUS_DI;
  logic        IBUS_BUSY;
  logic        IBUS_ACT;

  modport master (
    output IBUS_A, IBUS_DO, IBUS_BA, IBUS_WE, IBUS_REQ,
    input  IBUS_DI, IBUS_BUSY, IBUS_ACT
  );

  modport slave (
    input  IBUS_A, IBUS_DO, IBUS_BA, IBUS_WE, IBUS_REQ,
    output IBUS_DI, IBUS_BUSY, IBUS_ACT
  );
endinterface

// File: rtl/sh7604_ibus_lanes.sv
// Big-endian lane logic: byte enables and write replication for the
// issuing access, zero-extended read extraction for the active one.
module sh7604_ibus_lanes
  import sh7604_pkg::*;
(
  input  ibus_sz_e    wr_sz_i,
  input  logic [1:0]  wr_a_i,
  input  logic [31:0] wr_data_i,
  output logic [3:0]  ba_o,
  output logic [31:0] wr_data_o,
  input  ibus_sz_e    rd_sz_i,
  input  logic [1:0]  rd_a_i,
  input  logic [31:0] rd_data_i,
  output logic [31:0] rd_data_o
);

  always_comb begin
    ba_o      = 4'b1111;
    wr_data_o = wr_data_i;
    unique case (wr_sz_i)
      SZ_BYTE: begin
        ba_o      = 4'b1000 >> wr_a_i;
        wr_data_o = {4{wr_data_i[7:0]}};
      end
      SZ_WORD: begin
        ba_o      = wr_a_i[1] ? 4'b0011 : 4'b1100;
        wr_data_o = {2{wr_data_i[15:0]}};
      end
      default: begin
        ba_o      = 4'b1111;
        wr_data_o = wr_data_i;
      end
    endcase
  end

  always_comb begin
    rd_data_o = rd_data_i;
    unique case (rd_sz_i)
      SZ_BYTE: begin
        unique case (rd_a_i)
          2'd0: rd_data_o = {24'd0, rd_data_i[31:24]};
          2'd1: rd_data_o = {24'd0, rd_data_i[23:16]};
          2'd2: rd_data_o = {24'd0, rd_data_i[15:8]};
          default: rd_data_o = {24'd0, rd_data_i[7:0]};
        endcase
      end
      SZ_WORD: begin
        rd_data_o = rd_a_i[1] ? {16'd0, rd_data_i[15:0]}
                              : {16'd0, rd_data_i[31:16]};
      end
      default: rd_data_o = rd_data_i;
    endcase
  end

endmodule

// File: rtl/sh7604_ibus_master.sv
// CPU-to-internal-bus master for the SH7604 on-chip peripheral region.
// Ports: CLK/RST_N, CE_R/CE_F/EN strobes, CPU_* request side, ibus
// master bundle, BERR/ADDRERR single-CE_R error pulses.
module sh7604_ibus_master
  import sh7604_pkg::*;
#(
  parameter logic [31:0] REGION_BASE = REGION_BASE_DEF,
  parameter logic [7:0]  TIMEOUT     = TIMEOUT_DEF
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        CE_R,
  input  logic        CE_F,
  input  logic        EN,
  input  logic [31:0] CPU_A,
  input  logic [31:0] CPU_DI,
  output logic [31:0] CPU_DO,
  input  logic [1:0]  CPU_SZ,
  input  logic        CPU_WE,
  input  logic        CPU_REQ,
  output logic        CPU_BUSY,
  sh7604_ibus_if.master ibus,
  output logic        BERR,
  output logic        ADDRERR
);

  // Responder data is simply sampled on CE_R; CE_F has no role here.
  logic unused_ce_f;
  assign unused_ce_f = CE_F;

  ibus_state_e state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [31:0] a_q, a_d;
  logic [31:0] do_q, do_d;
  logic [3:0]  ba_q, ba_d;
  logic        we_q, we_d;
  logic        req_q, req_d;
  ibus_sz_e    sz_q, sz_d;
  logic [31:0] cpu_do_q, cpu_do_d;
  logic        berr_q, berr_d;
  logic        aerr_q, aerr_d;

  logic        ce;
  ibus_sz_e    sz_n;
  logic        in_reg;
  logic        mis;
  logic [7:0]  cnt_inc;
  logic [3:0]  wr_ba;
  logic [31:0] wr_data;
  logic [31:0] rd_data;

  assign ce      = EN & CE_R;
  assign sz_n    = norm_sz(CPU_SZ);
  assign in_reg  = CPU_A >= REGION_BASE;
  assign mis     = misaligned(sz_n, CPU_A[1:0]);
  assign cnt_inc = cnt_q + 8'd1;

  // Read extraction uses the latched access, so a CPU that changes
  // its address mid-cycle still gets the right lane.
  sh7604_ibus_lanes u_lanes (
    .wr_sz_i   (sz_n),
    .wr_a_i    (CPU_A[1:0]),
    .wr_data_i (CPU_DI),
    .ba_o      (wr_ba),
    .wr_data_o (wr_data),
    .rd_sz_i   (sz_q),
    .rd_a_i    (a_q[1:0]),
    .rd_data_i (ibus.IBUS_DI),
    .rd_data_o (rd_data)
  );

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q  <= ST_IDLE;
      cnt_q    <= 8'd0;
      a_q      <= 32'd0;
      do_q     <= 32'd0;
      ba_q     <= 4'd0;
      we_q     <= 1'b0;
      req_q    <= 1'b0;
      sz_q     <= SZ_BYTE;
      cpu_do_q <= 32'd0;
      berr_q   <= 1'b0;
      aerr_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      a_q      <= a_d;
      do_q     <= do_d;
      ba_q     <= ba_d;
      we_q     <= we_d;
      req_q    <= req_d;
      sz_q     <= sz_d;
      cpu_do_q <= cpu_do_d;
      berr_q   <= berr_d;
      aerr_q   <= aerr_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    a_d      = a_q;
    do_d     = do_q;
    ba_d     = ba_q;
    we_d     = we_q;
    req_d    = req_q;
    sz_d     = sz_q;
    cpu_do_d = cpu_do_q;
    berr_d   = berr_q;
    aerr_d   = aerr_q;
    if (ce) begin
      berr_d = 1'b0;
      aerr_d = 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          if (CPU_REQ && in_reg) begin
            if (mis) begin
              aerr_d = 1'b1;
            end else begin
              a_d     = CPU_A;
              do_d    = wr_data;
              ba_d    = wr_ba;
              we_d    = CPU_WE;
              sz_d    = sz_n;
              req_d   = 1'b1;
              cnt_d   = 8'd0;
              state_d = ST_ACCESS;
            end
          end
        end
        ST_ACCESS: begin
          if (!ibus.IBUS_BUSY) begin
            req_d   = 1'b0;
            state_d = ST_DONE;
            if (ibus.IBUS_ACT) begin
              if (!we_q) cpu_do_d = rd_data;
            end else begin
              berr_d = 1'b1;
              if (!we_q) cpu_do_d = 32'd0;
            end
          end else if (cnt_q != 8'hFF) begin
            // Saturating wait count; abort when it reaches TIMEOUT.
            cnt_d = cnt_inc;
            if (cnt_inc == TIMEOUT) begin
              berr_d   = 1'b1;
              cpu_do_d = 32'd0;
              req_d    = 1'b0;
              state_d  = ST_DONE;
            end
          end
        end
        ST_DONE: state_d = ST_IDLE;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  assign CPU_BUSY = CPU_REQ & in_reg & ~mis & (state_q != ST_DONE);

  assign CPU_DO        = cpu_do_q;
  assign BERR          = berr_q;
  assign ADDRERR       = aerr_q;
  assign ibus.IBUS_A   = a_q;
  assign ibus.IBUS_DO  = do_q;
  assign ibus.IBUS_BA  = ba_q;
  assign ibus.IBUS_WE  = we_q;
  assign ibus.IBUS_REQ = req_q;

endmodule

// File: tb/tb_sh7604_ibus_master.sv
// Self-checking bench for sh7604_ibus_master: directed and random
// accesses compared against a transaction-level reference model.
module tb_sh7604_ibus_master;

  logic        CLK;
  logic        RST_N;
  logic        CE_R;
  logic        CE_F;
  logic        EN;
  logic [31:0] CPU_A;
  logic [31:0] CPU_DI;
  logic [31:0] CPU_DO;
  logic [1:0]  CPU_SZ;
  logic        CPU_WE;
  logic        CPU_REQ;
  logic        CPU_BUSY;
  logic        BERR;
  logic        ADDRERR;

  int vectors;
  int miscompares;
  logic [31:0] exp_do;

  sh7604_ibus_if bus ();

  sh7604_ibus_master dut (
    .CLK      (CLK),
    .RST_N    (RST_N),
    .CE_R     (CE_R),
    .CE_F     (CE_F),
    .EN       (EN),
    .CPU_A    (CPU_A),
    .CPU_DI   (CPU_DI),
    .CPU_DO   (CPU_DO),
    .CPU_SZ   (CPU_SZ),
    .CPU_WE   (CPU_WE),
    .CPU_REQ  (CPU_REQ),
    .CPU_BUSY (CPU_BUSY),
    .ibus     (bus),
    .BERR     (BERR),
    .ADDRERR  (ADDRERR)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #5ms;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One CE_R strobe followed by one idle clock; returns on a negedge.
  task automatic ce_pulse();
    CE_R = 1'b1;
    @(negedge CLK);
    CE_R = 1'b0;
    @(negedge CLK);
  endtask

  function automatic int nbytes(input logic [1:0] sz);
    return (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
  endfunction

  function automatic logic [3:0] m_ba(input logic [31:0] a,
                                      input logic [1:0] sz);
    logic [3:0] ba;
    int off;
    ba = 4'd0;
    off = int'(a % 4);
    for (int i = 0; i < nbytes(sz); i++) ba[3 - (off + i)] = 1'b1;
    return ba;
  endfunction

  function automatic logic [31:0] m_wr(input logic [31:0] di,
                                       input logic [1:0] sz);
    if (nbytes(sz) == 1) return (di & 32'hFF) * 32'h01010101;
    if (nbytes(sz) == 2) return (di & 32'hFFFF) * 32'h00010001;
    return di;
  endfunction

  function automatic logic [31:0] m_rd(input logic [31:0] a,
                                       input logic [1:0] sz,
                                       input logic [31:0] d);
    int n;
    int off;
    logic [63:0] mask;
    n = nbytes(sz);
    off = int'(a % 4);
    mask = (64'd1 << (8 * n)) - 64'd1;
    return 32'((64'(d) >> (8 * (4 - off - n))) & mask);
  endfunction

  task automatic xfer(input logic [31:0] addr,
                      input logic [1:0] sz,
                      input logic we,
                      input logic [31:0] di,
                      input int busy_n,
                      input logic act,
                      input logic [31:0] idata,
                      input logic drop_req);
    logic in_r;
    logic mis;
    int k;
    int exp_k;
    logic exp_berr;
    in_r = addr >= 32'hFFFFFE00;
    mis = (addr % nbytes(sz)) != 0;
    CPU_A = addr;
    CPU_SZ = sz;
    CPU_WE = we;
    CPU_DI = di;
    CPU_REQ = 1'b1;
    bus.IBUS_BUSY = busy_n > 0;
    bus.IBUS_ACT = act;
    bus.IBUS_DI = idata;
    #1;
    chk("busy_pre", 32'(CPU_BUSY), 32'(in_r & ~mis));
    ce_pulse();
    if (!in_r || mis) begin
      chk("noreq", 32'(bus.IBUS_REQ), 32'd0);
      chk("addrerr", 32'(ADDRERR), 32'(in_r & mis));
      chk("busy_err", 32'(CPU_BUSY), 32'd0);
      CPU_REQ = 1'b0;
      ce_pulse();
      chk("addrerr_end", 32'(ADDRERR), 32'd0);
      chk("noreq_end", 32'(bus.IBUS_REQ), 32'd0);
      return;
    end
    chk("req", 32'(bus.IBUS_REQ), 32'd1);
    chk("ibus_a", bus.IBUS_A, addr);
    chk("ibus_do", bus.IBUS_DO, m_wr(di, sz));
    chk("ibus_ba", 32'(bus.IBUS_BA), 32'(m_ba(addr, sz)));
    chk("ibus_we", 32'(bus.IBUS_WE), 32'(we));
    k = 0;
    for (int g = 0; g < 400; g++) begin
      if (k == busy_n) bus.IBUS_BUSY = 1'b0;
      if (drop_req) CPU_REQ = 1'b0;
      ce_pulse();
      k++;
      if (!bus.IBUS_REQ) break;
    end
    exp_k = (busy_n >= 255) ? 255 : busy_n + 1;
    exp_berr = (busy_n >= 255) || !act;
    if (busy_n >= 255) exp_do = 32'd0;
    else if (!we) exp_do = act ? m_rd(addr, sz, idata) : 32'd0;
    chk("latency", k, exp_k);
    chk("berr", 32'(BERR), 32'(exp_berr));
    chk("cpu_do", CPU_DO, exp_do);
    chk("busy_done", 32'(CPU_BUSY), 32'd0);
    ce_pulse();
    chk("berr_end", 32'(BERR), 32'd0);
    chk("busy_idle", 32'(CPU_BUSY), 32'(CPU_REQ));
    chk("req_idle", 32'(bus.IBUS_REQ), 32'd0);
    CPU_REQ = 1'b0;
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    exp_do = 32'd0;
    RST_N = 1'b0;
    CE_R = 1'b0;
    CE_F = 1'b0;
    EN = 1'b1;
    CPU_A = 32'd0;
    CPU_DI = 32'd0;
    CPU_SZ = 2'd0;
    CPU_WE = 1'b0;
    CPU_REQ = 1'b0;
    bus.IBUS_DI = 32'd0;
    bus.IBUS_BUSY = 1'b0;
    bus.IBUS_ACT = 1'b0;
    repeat (3) @(negedge CLK);
    chk("rst_req", 32'(bus.IBUS_REQ), 32'd0);
    chk("rst_do", CPU_DO, 32'd0);
    chk("rst_ba", 32'(bus.IBUS_BA), 32'd0);
    chk("rst_berr", 32'(BERR | ADDRERR), 32'd0);
    chk("rst_busy", 32'(CPU_BUSY), 32'd0);
    RST_N = 1'b1;
    @(negedge CLK);

    xfer(32'hFFFFFE80, 2'd1, 1'b1, 32'h00005A07, 0, 1'b1,
         32'h0, 1'b0);
    xfer(32'hFFFFFE81, 2'd0, 1'b0, 32'h0, 0, 1'b1,
         32'h11223344, 1'b0);
    xfer(32'hFFFFFE02, 2'd2, 1'b0, 32'h0, 0, 1'b1,
         32'h0, 1'b0);
    xfer(32'hFFFFFF00, 2'd0, 1'b0, 32'h0, 0, 1'b0,
         32'hAABBCCDD, 1'b0);
    xfer(32'hFFFFFE10, 2'd2, 1'b0, 32'h0, 1000, 1'b1,
         32'h12345678, 1'b0);
    xfer(32'hFFFFFE14, 2'd3, 1'b0, 32'h0, 3, 1'b1,
         32'hCAFEF00D, 1'b0);
    xfer(32'hFFFFFE22, 2'd1, 1'b0, 32'h0, 2, 1'b1,
         32'h8899AABB, 1'b1);
    xfer(32'hFFFFFD00, 2'd2, 1'b1, 32'h1, 0, 1'b1,
         32'h0, 1'b0);

    CPU_A = 32'hFFFFFE82;
    CPU_SZ = 2'd1;
    CPU_WE = 1'b0;
    CPU_REQ = 1'b1;
    bus.IBUS_BUSY = 1'b0;
    bus.IBUS_ACT = 1'b1;
    bus.IBUS_DI = 32'h0BADBEEF;
    ce_pulse();
    chk("en_issue", 32'(bus.IBUS_REQ), 32'd1);
    EN = 1'b0;
    ce_pulse();
    ce_pulse();
    chk("en_hold_req", 32'(bus.IBUS_REQ), 32'd1);
    chk("en_hold_do", CPU_DO, exp_do);
    EN = 1'b1;
    ce_pulse();
    exp_do = 32'h0000BEEF;
    chk("en_resume_req", 32'(bus.IBUS_REQ), 32'd0);
    chk("en_resume_do", CPU_DO, exp_do);
    ce_pulse();
    CPU_REQ = 1'b0;

    CPU_A = 32'hFFFFFE40;
    CPU_SZ = 2'd2;
    CPU_WE = 1'b1;
    CPU_DI = 32'hDEADBEEF;
    CPU_REQ = 1'b1;
    bus.IBUS_BUSY = 1'b1;
    ce_pulse();
    ce_pulse();
    chk("mid_req", 32'(bus.IBUS_REQ), 32'd1);
    CPU_REQ = 1'b0;
    RST_N = 1'b0;
    #1;
    chk("mrst_req", 32'(bus.IBUS_REQ), 32'd0);
    chk("mrst_we", 32'(bus.IBUS_WE), 32'd0);
    chk("mrst_a", bus.IBUS_A, 32'd0);
    chk("mrst_do", bus.IBUS_DO, 32'd0);
    chk("mrst_ba", 32'(bus.IBUS_BA), 32'd0);
    chk("mrst_cpudo", CPU_DO, 32'd0);
    chk("mrst_err", 32'(BERR | ADDRERR | CPU_BUSY), 32'd0);
    exp_do = 32'd0;
    @(negedge CLK);
    RST_N = 1'b1;
    @(negedge CLK);
    xfer(32'hFFFFFE43, 2'd0, 1'b0, 32'h0, 1, 1'b1,
         32'h01020304, 1'b0);

    for (int i = 0; i < 40; i++) begin
      logic [31:0] a;
      if ($urandom_range(0, 9) == 0)
        a = 32'hFFFFFD00 + 32'($urandom_range(0, 255));
      else
        a = 32'hFFFFFE00 + 32'($urandom_range(0, 511));
      xfer(a, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
           $urandom, $urandom_range(0, 4),
           $urandom_range(0, 5) != 0, $urandom, 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
